// File: rtl/mux2_rr_stage.sv
// Round-robin two-source selector feeding one registered output word, with per-source beat counters.
// One cycle from source transfer to out_valid; the source readies drop whenever the held word is not drained.
module mux2_rr_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_src_q,   out_src_d;
    logic             last_src_q,  last_src_d;
    logic [CNT_W-1:0] a_cnt_q,     a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q,     b_cnt_d;

    logic can_load;
    logic grant_a;
    logic grant_b;
    logic xfer_a;
    logic xfer_b;

    always_comb begin
        can_load = !out_valid_q || out_ready;
        // On contention the source that did not win last time goes first.
        grant_b  = b_valid && (!a_valid || !last_src_q);
        grant_a  = a_valid && !grant_b;
        xfer_a   = can_load && grant_a;
        xfer_b   = can_load && grant_b;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_src_d  = last_src_q;
        a_cnt_d     = a_cnt_q;
        b_cnt_d     = b_cnt_q;

        if (xfer_a) begin
            out_valid_d = 1'b1;
            out_data_d  = a_data;
            out_src_d   = 1'b0;
            last_src_d  = 1'b0;
            a_cnt_d     = a_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (xfer_b) begin
            out_valid_d = 1'b1;
            out_data_d  = b_data;
            out_src_d   = 1'b1;
            last_src_d  = 1'b1;
            b_cnt_d     = b_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            last_src_q  <= 1'b1;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_src_q  <= last_src_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
        end
    end

    assign a_ready   = xfer_a;
    assign b_ready   = xfer_b;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign a_count   = a_cnt_q;
    assign b_count   = b_cnt_q;

endmodule

// File: doc/mux2_rr_stage.md
Name: mux2_rr_stage

Overview:
- Registered two-source selector stage for the datapath. It sits directly upstream of the 16-bit two-way mux consumer logic.
- Arbitrates between two valid/ready source channels (A, B) with round-robin fairness and generates the select value.
- Captures the selected word into an output register with a valid/ready handshake.
- Turns the combinational 16-bit select path into a pipelined, back-pressurable stage with per-source beat counters.

Parameters:
- WIDTH, 16, data width of both sources and the output.
- CNT_W, 8, width of the per-source accepted-beat counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  source A has a word.
- a_data  input  WIDTH  source A word.
- a_ready  output  1  source A word accepted this cycle.
- b_valid  input  1  source B has a word.
- b_data  input  WIDTH  source B word.
- b_ready  output  1  source B word accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_src  output  1  select value of the held word: 0 = A, 1 = B.
- out_ready  input  1  consumer accepts the output word.
- a_count  output  CNT_W  A beats accepted since reset, wraps.
- b_count  output  CNT_W  B beats accepted since reset, wraps.

Behaviour:
- Reset (asynchronous on rst_n low, held until rst_n goes high):
  - out_valid = 0, out_data = 0, out_src = 0.
  - a_count = 0, b_count = 0.
  - Priority pointer last_src = 1, so A wins the first contention.
- Output register:
  - can_load = !out_valid || out_ready. This path is combinational from out_ready.
- Grant (combinational):
  - Only a_valid: grant A.
  - Only b_valid: grant B.
  - Both valid: grant the source != last_src.
  - Neither valid: no grant.
- Ready outputs:
  - a_ready = can_load && grant == A.
  - b_ready = can_load && grant == B.
  - At most one ready is high per cycle.
  - Ready may depend combinationally on valid inputs. It never depends on data.
- Transfer on the rising edge when (a_valid && a_ready) or (b_valid && b_ready):
  - out_data <= granted word, out_src <= granted source, out_valid <= 1.
  - last_src <= granted source.
  - The granted counter increments by 1, wrapping from 2^CNT_W-1 to 0.
- Drain: out_ready && out_valid with no new transfer -> out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous drain and load: the new word replaces the old one in the same edge, out_valid stays 1. This gives full throughput of 1 word/cycle.
- Stall: out_valid && !out_ready -> both ready outputs are 0, out_data/out_src/out_valid stable, last_src and counters unchanged.
- Fairness:
  - last_src updates only on an actual transfer, never on a stalled grant.
  - With both sources continuously valid and out_ready=1, accepted sources alternate A,B,A,B starting with A after reset.
- Source protocol: a source that is not granted holds its valid and data. The block does not check this.
- Latency: 1 cycle from source transfer to out_valid and out_data.
- Reset mid-operation: any held word is dropped, out_valid = 0 immediately (asynchronous), and the pointer returns to the reset value.
- There are no X outputs after reset, including when inputs are X while valid = 0.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, a_count and b_count all 0 within the same cycle, before the next clk edge. After release, first contention grants A.
- Single source: a_valid=1, a_data=16'h0001, b_valid=0, out_ready=1 -> a_ready=1. Next cycle out_valid=1, out_data=16'h0001, out_src=0, a_count=1.
- Contention: both valid, a_data=16'h0001, b_data=16'h1232, out_ready=1, for 4 cycles -> outputs h0001, h1232, h0001, h1232 with out_src 0,1,0,1. a_count=2, b_count=2.
- Back-pressure: out_ready=0 with out_valid=1 for 5 cycles and both sources valid -> a_ready=b_ready=0, outputs frozen. Release -> next grant is the source opposite the held word's out_src.
- Full throughput: A only, a_data incrementing from 0, out_ready=1 for 20 cycles -> 20 consecutive transfers with no bubble and out_data matching in order.
- Counter wrap: 256 A transfers with CNT_W=8 -> a_count returns to 0 and b_count stays 0.
